// File: rtl/dma_uart_read_engine.sv
`timescale 1ns/1ps
// dma_uart_read_engine
// Read-path companion to the UART DMA write engine. A read request sends one
// command byte ({1'b0, addr}) over the shared UART TX byte interface, then
// collects a two-byte fp16 reply (MSB first) from the UART RX byte interface.
// The reply is returned widened to an 18-bit cherry float {fp16, 2'b00}.
// One request is in flight at a time. Each reply byte has its own idle timeout.
// RX bytes that arrive while no reply is expected are dropped and counted.
module dma_uart_read_engine #(
  parameter int unsigned CLK_HZ         = 50000000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned ADDR_W         = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              busy_o,
  output logic              tx_en_o,
  output logic [7:0]        tx_data_o,
  input  logic              tx_busy_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  output logic              resp_valid_o,
  output logic [17:0]       resp_data_o,
  output logic [ADDR_W-1:0] resp_addr_o,
  output logic              resp_timeout_o,
  output logic [7:0]        stray_count_o
);

  // Counter is wide enough to hold TIMEOUT_CYCLES itself, so it never wraps.
  localparam int unsigned    CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  // Catch meaningless parameter values at elaboration time.
  if (TIMEOUT_CYCLES < 1 || CLK_HZ == 0) begin : g_bad_params
    $error("dma_uart_read_engine: TIMEOUT_CYCLES must be >= 1 and CLK_HZ nonzero");
  end

  typedef enum logic [2:0] {
    IDLE,
    SEND_CMD,
    TX_GAP,
    TX_WAIT,
    WAIT_MSB,
    WAIT_LSB
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          msb_q, msb_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                tx_en_q, tx_en_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                resp_valid_q, resp_valid_d;
  logic [17:0]         resp_data_q, resp_data_d;
  logic [ADDR_W-1:0]   resp_addr_q, resp_addr_d;
  logic                resp_timeout_q, resp_timeout_d;
  logic [7:0]          stray_q, stray_d;

  logic [CNT_W-1:0]    cnt_inc;
  logic                timeout_hit;

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Next-state and registered-output logic for the read transaction.
  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    msb_d          = msb_q;
    cnt_d          = cnt_q;
    busy_d         = busy_q;
    tx_en_d        = 1'b0;
    tx_data_d      = tx_data_q;
    resp_valid_d   = 1'b0;
    resp_data_d    = resp_data_q;
    resp_addr_d    = resp_addr_q;
    resp_timeout_d = 1'b0;
    stray_d        = stray_q;
    timeout_hit    = 1'b0;

    // Bytes outside the reply window are discarded; the count saturates.
    if (rx_valid_i && !(state_q inside {WAIT_MSB, WAIT_LSB}) && stray_q != 8'hFF) begin
      stray_d = stray_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          busy_d  = 1'b1;
          state_d = SEND_CMD;
        end
      end
      SEND_CMD: begin
        // Bit 7 clear marks a read command; the write engine sets it.
        tx_en_d   = 1'b1;
        tx_data_d = {1'b0, 7'(addr_q)};
        state_d   = TX_GAP;
      end
      TX_GAP: begin
        // One idle cycle so the UART can raise tx_busy for the new byte.
        state_d = TX_WAIT;
      end
      TX_WAIT: begin
        if (!tx_busy_i) begin
          cnt_d   = '0;
          state_d = WAIT_MSB;
        end
      end
      WAIT_MSB: begin
        if (rx_valid_i) begin
          msb_d   = rx_data_i;
          cnt_d   = '0;
          state_d = WAIT_LSB;
        end else begin
          cnt_d       = cnt_inc;
          timeout_hit = (cnt_inc == TO_LIMIT);
        end
      end
      WAIT_LSB: begin
        // A byte on the limit cycle still wins over the timeout.
        if (rx_valid_i) begin
          resp_valid_d   = 1'b1;
          resp_data_d    = {msb_q, rx_data_i, 2'b00};
          resp_addr_d    = addr_q;
          resp_timeout_d = 1'b0;
          busy_d         = 1'b0;
          state_d        = IDLE;
        end else begin
          cnt_d       = cnt_inc;
          timeout_hit = (cnt_inc == TO_LIMIT);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (timeout_hit) begin
      resp_valid_d   = 1'b1;
      resp_timeout_d = 1'b1;
      resp_data_d    = '0;
      resp_addr_d    = addr_q;
      busy_d         = 1'b0;
      state_d        = IDLE;
    end
  end

  // State and output registers; reset drops any in-flight request.
  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      msb_q          <= '0;
      cnt_q          <= '0;
      busy_q         <= 1'b0;
      tx_en_q        <= 1'b0;
      tx_data_q      <= '0;
      resp_valid_q   <= 1'b0;
      resp_data_q    <= '0;
      resp_addr_q    <= '0;
      resp_timeout_q <= 1'b0;
      stray_q        <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      msb_q          <= msb_d;
      cnt_q          <= cnt_d;
      busy_q         <= busy_d;
      tx_en_q        <= tx_en_d;
      tx_data_q      <= tx_data_d;
      resp_valid_q   <= resp_valid_d;
      resp_data_q    <= resp_data_d;
      resp_addr_q    <= resp_addr_d;
      resp_timeout_q <= resp_timeout_d;
      stray_q        <= stray_d;
    end
  end

  assign busy_o         = busy_q;
  assign tx_en_o        = tx_en_q;
  assign tx_data_o      = tx_data_q;
  assign resp_valid_o   = resp_valid_q;
  assign resp_data_o    = resp_data_q;
  assign resp_addr_o    = resp_addr_q;
  assign resp_timeout_o = resp_timeout_q;
  assign stray_count_o  = stray_q;

endmodule

// File: tb/tb_dma_uart_read_engine.sv
`timescale 1ns/1ps
// Testbench for dma_uart_read_engine: a cycle-by-cycle vector table followed by
// hand-written sequences for timeout, stray saturation, reset and held requests.
module tb_dma_uart_read_engine;

  localparam int unsigned TO = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [6:0]  req_addr;
  logic        busy;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        resp_valid;
  logic [17:0] resp_data;
  logic [6:0]  resp_addr;
  logic        resp_timeout;
  logic [7:0]  stray_count;

  int checks = 0;
  int errors = 0;
  int txen_cnt = 0;
  int resp_cnt = 0;

  dma_uart_read_engine #(
    .CLK_HZ(50000000),
    .TIMEOUT_CYCLES(TO),
    .ADDR_W(7)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid_i   (req_valid),
    .req_addr_i    (req_addr),
    .busy_o        (busy),
    .tx_en_o       (tx_en),
    .tx_data_o     (tx_data),
    .tx_busy_i     (tx_busy),
    .rx_valid_i    (rx_valid),
    .rx_data_i     (rx_data),
    .resp_valid_o  (resp_valid),
    .resp_data_o   (resp_data),
    .resp_addr_o   (resp_addr),
    .resp_timeout_o(resp_timeout),
    .stray_count_o (stray_count)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (tx_en)      txen_cnt <= txen_cnt + 1;
    if (resp_valid) resp_cnt <= resp_cnt + 1;
  end

  // Hard stop in case something wedges the run.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        req;
    logic [6:0]  addr;
    logic        txb;
    logic        rxv;
    logic [7:0]  rxd;
    logic        e_busy;
    logic        e_tx_en;
    logic [7:0]  e_tx_data;
    logic        e_rv;
    logic [17:0] e_rd;
    logic [6:0]  e_ra;
    logic        e_rt;
    logic [7:0]  e_stray;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    tx_busy   = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic start_req(input logic [6:0] a);
    req_valid = 1'b1;
    req_addr  = a;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_tx_en(input string name, input logic [7:0] exp_data);
    int n = 0;
    while (!tx_en && n < 20) begin
      tick();
      n++;
    end
    check({name, " tx_en seen"}, 32'(tx_en), 32'd1);
    check({name, " tx_data"}, 32'(tx_data), 32'(exp_data));
  endtask

  // Called just after tx_en is seen: hold tx_busy for n cycles, then land in WAIT_MSB.
  task automatic finish_tx(input int n);
    tx_busy = (n > 0);
    repeat (n) tick();
    tx_busy = 1'b0;
    tick();
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  initial begin
    int tx0;
    int r0;

    // req addr txb rxv rxd | busy tx_en tx_data rv rd ra rt stray
    vecs[0]  = '{1'b1, 7'h2A, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 18'h00000, 7'h00, 1'b0, 8'd0};
    vecs[1]  = '{1'b0, 7'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h2A, 1'b0, 18'h00000, 7'h00, 1'b0, 8'd0};
    vecs[2]  = '{1'b0, 7'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h2A, 1'b0, 18'h00000, 7'h00, 1'b0, 8'd0};
    vecs[3]  = '{1'b0, 7'h00, 1'b1, 1'b1, 8'h77, 1'b1, 1'b0, 8'h2A, 1'b0, 18'h00000, 7'h00, 1'b0, 8'd1};
    vecs[4]  = '{1'b0, 7'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h2A, 1'b0, 18'h00000, 7'h00, 1'b0, 8'd1};
    vecs[5]  = '{1'b0, 7'h00, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 8'h2A, 1'b0, 18'h00000, 7'h00, 1'b0, 8'd1};
    vecs[6]  = '{1'b1, 7'h11, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h2A, 1'b0, 18'h00000, 7'h00, 1'b0, 8'd1};
    vecs[7]  = '{1'b0, 7'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 8'h2A, 1'b1, 18'h0F004, 7'h2A, 1'b0, 8'd1};
    vecs[8]  = '{1'b1, 7'h55, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h2A, 1'b0, 18'h0F004, 7'h2A, 1'b0, 8'd1};
    vecs[9]  = '{1'b0, 7'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h55, 1'b0, 18'h0F004, 7'h2A, 1'b0, 8'd1};
    vecs[10] = '{1'b0, 7'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h55, 1'b0, 18'h0F004, 7'h2A, 1'b0, 8'd1};
    vecs[11] = '{1'b0, 7'h00, 1'b0, 1'b1, 8'hEE, 1'b1, 1'b0, 8'h55, 1'b0, 18'h0F004, 7'h2A, 1'b0, 8'd2};
    vecs[12] = '{1'b0, 7'h00, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 8'h55, 1'b0, 18'h0F004, 7'h2A, 1'b0, 8'd2};
    vecs[13] = '{1'b0, 7'h00, 1'b0, 1'b1, 8'hFC, 1'b0, 1'b0, 8'h55, 1'b1, 18'h3FFF0, 7'h55, 1'b0, 8'd2};
    vecs[14] = '{1'b0, 7'h00, 1'b0, 1'b1, 8'hAB, 1'b0, 1'b0, 8'h55, 1'b0, 18'h3FFF0, 7'h55, 1'b0, 8'd3};

    // Reset state.
    do_reset();
    check("reset busy",        32'(busy),         32'd0);
    check("reset tx_en",       32'(tx_en),        32'd0);
    check("reset tx_data",     32'(tx_data),      32'd0);
    check("reset resp_valid",  32'(resp_valid),   32'd0);
    check("reset resp_data",   32'(resp_data),    32'd0);
    check("reset resp_addr",   32'(resp_addr),    32'd0);
    check("reset resp_timeout",32'(resp_timeout), 32'd0);
    check("reset stray_count", 32'(stray_count),  32'd0);

    // Cycle-by-cycle table: one full read, an ignored request, back-to-back read.
    for (int i = 0; i < NV; i++) begin
      req_valid = vecs[i].req;
      req_addr  = vecs[i].addr;
      tx_busy   = vecs[i].txb;
      rx_valid  = vecs[i].rxv;
      rx_data   = vecs[i].rxd;
      tick();
      check($sformatf("vec%0d busy", i),         32'(busy),         32'(vecs[i].e_busy));
      check($sformatf("vec%0d tx_en", i),        32'(tx_en),        32'(vecs[i].e_tx_en));
      check($sformatf("vec%0d tx_data", i),      32'(tx_data),      32'(vecs[i].e_tx_data));
      check($sformatf("vec%0d resp_valid", i),   32'(resp_valid),   32'(vecs[i].e_rv));
      check($sformatf("vec%0d resp_data", i),    32'(resp_data),    32'(vecs[i].e_rd));
      check($sformatf("vec%0d resp_addr", i),    32'(resp_addr),    32'(vecs[i].e_ra));
      check($sformatf("vec%0d resp_timeout", i), 32'(resp_timeout), 32'(vecs[i].e_rt));
      check($sformatf("vec%0d stray", i),        32'(stray_count),  32'(vecs[i].e_stray));
    end
    req_valid = 1'b0;
    rx_valid  = 1'b0;
    tx_busy   = 1'b0;

    // Basic read: addr 0x15, tx_busy 20 cycles, reply D2 48.
    do_reset();
    tx0 = txen_cnt;
    r0  = resp_cnt;
    start_req(7'h15);
    wait_tx_en("basic", 8'h15);
    finish_tx(20);
    send_byte(8'hD2);
    tick();
    check("basic busy before lsb", 32'(busy), 32'd1);
    send_byte(8'h48);
    check("basic resp_valid", 32'(resp_valid),   32'd1);
    check("basic resp_data",  32'(resp_data),    32'h34920);
    check("basic resp_addr",  32'(resp_addr),    32'h15);
    check("basic timeout",    32'(resp_timeout), 32'd0);
    check("basic busy falls", 32'(busy),         32'd0);
    tick();
    tick();
    check("basic tx_en pulses", 32'(txen_cnt - tx0), 32'd1);
    check("basic resp pulses",  32'(resp_cnt - r0),  32'd1);

    // Timeout on the LSB: response 100 cycles after the MSB strobe edge.
    start_req(7'h09);
    wait_tx_en("timeout", 8'h09);
    finish_tx(0);
    send_byte(8'hD2);
    repeat (TO - 1) tick();
    check("timeout not early rv",   32'(resp_valid), 32'd0);
    check("timeout not early busy", 32'(busy),       32'd1);
    tick();
    check("timeout resp_valid", 32'(resp_valid),   32'd1);
    check("timeout flag",       32'(resp_timeout), 32'd1);
    check("timeout resp_data",  32'(resp_data),    32'd0);
    check("timeout resp_addr",  32'(resp_addr),    32'h09);
    check("timeout busy",       32'(busy),         32'd0);
    tick();
    check("timeout rv pulse ends",   32'(resp_valid),   32'd0);
    check("timeout flag pulse ends", 32'(resp_timeout), 32'd0);

    // LSB arriving on the limit cycle wins over the timeout.
    start_req(7'h33);
    wait_tx_en("edge", 8'h33);
    finish_tx(1);
    send_byte(8'h12);
    repeat (TO - 1) tick();
    check("edge no early rv", 32'(resp_valid), 32'd0);
    send_byte(8'h34);
    check("edge resp_valid", 32'(resp_valid),   32'd1);
    check("edge timeout",    32'(resp_timeout), 32'd0);
    check("edge resp_data",  32'(resp_data),    32'h048D0);
    check("edge resp_addr",  32'(resp_addr),    32'h33);

    // Strays: three in IDLE, one in TX_WAIT, then 300 more to saturate.
    do_reset();
    r0 = resp_cnt;
    repeat (3) begin
      send_byte(8'hA5);
      tick();
    end
    check("stray idle count", 32'(stray_count), 32'd3);
    start_req(7'h44);
    wait_tx_en("stray", 8'h44);
    tx_busy = 1'b1;
    tick();
    tick();
    send_byte(8'h5A);
    check("stray tx_wait count", 32'(stray_count), 32'd4);
    rx_valid = 1'b1;
    rx_data  = 8'hC3;
    repeat (300) tick();
    rx_valid = 1'b0;
    check("stray saturate", 32'(stray_count), 32'd255);
    check("stray no resp",  32'(resp_cnt - r0), 32'd0);
    check("stray still busy", 32'(busy), 32'd1);
    tx_busy = 1'b0;
    tick();
    tick();
    send_byte(8'h01);
    send_byte(8'h02);
    check("stray then read data", 32'(resp_data), 32'h00408);
    check("stray held at 255",    32'(stray_count), 32'd255);

    // req_valid held high with a different address during a transaction.
    do_reset();
    tx0 = txen_cnt;
    start_req(7'h21);
    req_valid = 1'b1;
    req_addr  = 7'h5A;
    repeat (5) tick();
    req_valid = 1'b0;
    check("held busy", 32'(busy), 32'd1);
    tx_busy = 1'b0;
    tick();
    send_byte(8'hAB);
    send_byte(8'hCD);
    check("held resp_valid", 32'(resp_valid), 32'd1);
    check("held resp_addr",  32'(resp_addr),  32'h21);
    check("held resp_data",  32'(resp_data),  32'h2AF34);
    repeat (4) tick();
    check("held one tx_en", 32'(txen_cnt - tx0), 32'd1);

    // Reset while tx_en is high forces it low.
    start_req(7'h60);
    wait_tx_en("rst_tx", 8'h60);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_tx tx_en", 32'(tx_en), 32'd0);
    check("rst_tx busy",  32'(busy),  32'd0);

    // Reset in WAIT_LSB drops the request; a new read uses fresh bytes.
    r0 = resp_cnt;
    start_req(7'h40);
    wait_tx_en("rst_lsb", 8'h40);
    finish_tx(0);
    send_byte(8'h99);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_lsb busy",  32'(busy),        32'd0);
    check("rst_lsb stray", 32'(stray_count), 32'd0);
    repeat (TO + 10) tick();
    check("rst_lsb no resp", 32'(resp_cnt - r0), 32'd0);
    start_req(7'h41);
    wait_tx_en("rst_new", 8'h41);
    finish_tx(2);
    send_byte(8'h3C);
    send_byte(8'h00);
    check("rst_new resp_valid", 32'(resp_valid),   32'd1);
    check("rst_new resp_data",  32'(resp_data),    32'h0F000);
    check("rst_new resp_addr",  32'(resp_addr),    32'h41);
    check("rst_new timeout",    32'(resp_timeout), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
